// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch-stage types and defaults
package fetch_stage_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_BUFFERED,
    ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - one-entry skid register holding a beat that arrived during a stall
module fetch_buffer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            drain,
  input  logic            clear,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_inst,
  output logic [XLEN-1:0] buf_pc,
  output logic [31:0]     buf_inst,
  output logic            buf_valid
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_pc    <= '0;
      buf_inst  <= '0;
      buf_valid <= 1'b0;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_pc    <= load_pc;
      buf_inst  <= load_inst;
      buf_valid <= 1'b1;
    end else if (drain) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: fetch PC, imem req/ready handshake, IF/ID register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = NOP_INST_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            PC_write,
  input  logic            IF_ID_write,
  input  logic            IF_flush,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            halt,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] IF_ID_pc,
  output logic [31:0]     IF_ID_inst,
  output logic            IF_ID_valid
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic            stall;
  logic            beat;
  logic            buf_load;
  logic            buf_drain;
  logic [XLEN-1:0] buf_pc;
  logic [31:0]     buf_inst;
  logic            buf_valid;

  assign stall     = ~PC_write | ~IF_ID_write;
  assign beat      = imem_req & imem_ready;
  assign imem_addr = pc;
  assign buf_load  = beat & stall & ~IF_flush;
  assign buf_drain = buf_valid & ~stall & ~IF_flush;

  fetch_buffer #(.XLEN(XLEN)) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (buf_load),
    .drain     (buf_drain),
    .clear     (IF_flush),
    .load_pc   (pc),
    .load_inst (imem_rdata),
    .buf_pc    (buf_pc),
    .buf_inst  (buf_inst),
    .buf_valid (buf_valid)
  );

  // imem_req is registered alongside the state so it is glitch-free toward memory
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      imem_req <= 1'b0;
    end else if (halt) begin
      state    <= ST_HALTED;
      imem_req <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (buf_load) begin
            state    <= ST_BUFFERED;
            imem_req <= 1'b0;
          end
        end
        ST_BUFFERED: begin
          if (IF_flush || !stall) begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= ST_HALTED;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (IF_flush) begin
      pc <= redirect_target;
    end else if (beat) begin
      pc <= pc + PC_STEP;
    end
  end

  // Buffered beat is always older than a live beat, so it has priority into IF/ID
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      IF_ID_pc    <= '0;
      IF_ID_inst  <= NOP_INST;
      IF_ID_valid <= 1'b0;
    end else if (IF_flush) begin
      IF_ID_inst  <= NOP_INST;
      IF_ID_valid <= 1'b0;
    end else if (!stall) begin
      if (buf_valid) begin
        IF_ID_pc    <= buf_pc;
        IF_ID_inst  <= buf_inst;
        IF_ID_valid <= 1'b1;
      end else if (beat) begin
        IF_ID_pc    <= pc;
        IF_ID_inst  <= imem_rdata;
        IF_ID_valid <= 1'b1;
      end else begin
        IF_ID_inst  <= NOP_INST;
        IF_ID_valid <= 1'b0;
      end
    end
  end

endmodule
